// File: rtl/gfx_pkg.sv
// Shared encodings and defaults for the VRAM bus arbiter.
package gfx_pkg;

  // Address-mux select / bus owner encoding.
  localparam logic [1:0] OWN_VGA = 2'b00;
  localparam logic [1:0] OWN_DMA = 2'b01;
  localparam logic [1:0] OWN_CPU = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StAccess
  } arb_state_e;

  localparam int unsigned DEF_ACCESS_CYCLES = 2;
  localparam int unsigned DEF_TURNAROUND    = 1;

endpackage

// File: rtl/gfx_rr_pick.sv
// Two-requester round-robin picker: on a tie, the requester that did not complete last wins.
module gfx_rr_pick (
  input  logic clk,
  input  logic rst_b,
  input  logic req_dma,
  input  logic req_cpu,
  input  logic upd,
  input  logic upd_cpu,
  output logic pick_cpu
);

  logic last_cpu;

  // Remember the owner of the last acknowledged access; reset favours DMA.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      last_cpu <= 1'b1;
    end else if (upd) begin
      last_cpu <= upd_cpu;
    end
  end

  assign pick_cpu = req_cpu & (~req_dma | ~last_cpu);

endmodule

// File: rtl/gfx_vbus_arb.sv
// Shared VRAM bus arbiter: VGA owns the bus unless i_free_vbus is high; DMA and CPU
// share the free windows round-robin. Optional abort counter: GFX_VBUS_ABORT_CNT_EN.
module gfx_vbus_arb
  import gfx_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int unsigned TURNAROUND    = DEF_TURNAROUND
) (
  input  logic       i_clk,
  input  logic       i_rst_b,
  input  logic       i_free_vbus,
  input  logic       i_dma_req,
  output logic       o_dma_gnt,
  output logic       o_dma_ack,
  input  logic       i_cpu_req,
  input  logic       i_cpu_we_b,
  output logic       o_cpu_gnt,
  output logic       o_cpu_ack,
  output logic [1:0] o_addr_sel,
  output logic       o_vram_we_b,
  output logic       o_vram_oe_b,
  output logic       o_busy
`ifdef GFX_VBUS_ABORT_CNT_EN
  ,
  output logic [7:0] o_abort_cnt
`endif
);

  arb_state_e state;
  logic [1:0] owner;
  logic       is_wr;
  logic [7:0] cnt;

  logic       pick_cpu;
  logic [1:0] win;
  logic       launch_wr;
  logic       any_req, own_req;
  logic       acc_last, in_grant, abort, launch, direct, turn_last, ack_set;

  gfx_rr_pick u_rr_pick (
    .clk      (i_clk),
    .rst_b    (i_rst_b),
    .req_dma  (i_dma_req),
    .req_cpu  (i_cpu_req),
    .upd      (ack_set),
    .upd_cpu  (owner == OWN_CPU),
    .pick_cpu (pick_cpu)
  );

  assign win       = pick_cpu ? OWN_CPU : OWN_DMA;
  assign launch_wr = pick_cpu ? ~i_cpu_we_b : 1'b1;
  assign any_req   = i_dma_req | i_cpu_req;
  assign own_req   = (owner == OWN_CPU) ? i_cpu_req : i_dma_req;
  assign acc_last  = (state == StAccess) && (cnt == 8'(ACCESS_CYCLES - 1));
  // The ack cycle is already committed, so only earlier grant cycles can abort.
  assign in_grant  = (state == StTurn) || ((state == StAccess) && !acc_last);
  assign abort     = in_grant && (!i_free_vbus || !own_req);
  assign launch    = i_free_vbus && any_req && ((state == StIdle) || acc_last);
  // Keeping the same owner needs no turnaround.
  assign direct    = (TURNAROUND == 0) || (acc_last && (win == owner));
  assign turn_last = (state == StTurn) && (cnt == 8'(TURNAROUND - 1));
  assign ack_set   = (state == StAccess) && !abort && (cnt == 8'(ACCESS_CYCLES - 2));

  // Arbitration FSM; every output is registered from the decision taken at this edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      state       <= StIdle;
      owner       <= OWN_VGA;
      is_wr       <= 1'b0;
      cnt         <= '0;
      o_addr_sel  <= OWN_VGA;
      o_vram_we_b <= 1'b1;
      o_vram_oe_b <= 1'b1;
      o_dma_gnt   <= 1'b0;
      o_cpu_gnt   <= 1'b0;
      o_dma_ack   <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_dma_ack <= 1'b0;
      o_cpu_ack <= 1'b0;
      if (launch) begin
        owner      <= win;
        is_wr      <= launch_wr;
        cnt        <= '0;
        o_addr_sel <= win;
        o_dma_gnt  <= ~pick_cpu;
        o_cpu_gnt  <= pick_cpu;
        o_busy     <= 1'b1;
        if (direct) begin
          state       <= StAccess;
          o_vram_we_b <= ~launch_wr;
          o_vram_oe_b <= launch_wr;
        end else begin
          state       <= StTurn;
          o_vram_we_b <= 1'b1;
          o_vram_oe_b <= 1'b1;
        end
      end else if (abort || acc_last || (state == StIdle)) begin
        state       <= StIdle;
        owner       <= OWN_VGA;
        cnt         <= '0;
        o_addr_sel  <= OWN_VGA;
        o_vram_we_b <= 1'b1;
        o_vram_oe_b <= 1'b1;
        o_dma_gnt   <= 1'b0;
        o_cpu_gnt   <= 1'b0;
        o_busy      <= 1'b0;
      end else if (turn_last) begin
        state       <= StAccess;
        cnt         <= '0;
        o_vram_we_b <= ~is_wr;
        o_vram_oe_b <= is_wr;
      end else begin
        cnt <= cnt + 8'd1;
        if (ack_set) begin
          // Last access cycle: release the write strobe so data is held.
          o_vram_we_b <= 1'b1;
          o_dma_ack   <= (owner == OWN_DMA);
          o_cpu_ack   <= (owner == OWN_CPU);
        end
      end
    end
  end

`ifdef GFX_VBUS_ABORT_CNT_EN
  // Saturating count of grants lost because VGA reclaimed the bus.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      o_abort_cnt <= '0;
    end else if (in_grant && !i_free_vbus && (o_abort_cnt != 8'hff)) begin
      o_abort_cnt <= o_abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gfx_vbus_arb.sv
// Self-checking bench for gfx_vbus_arb: vector table, directed corner sequences and
// randomized traffic against a transaction-position reference model.
module tb_gfx_vbus_arb;

  localparam int AC = 2;
  localparam int TA = 1;

  logic       clk = 1'b0;
  logic       rst_b, free, dma_req, cpu_req, cpu_we_b;
  logic       dma_gnt, dma_ack, cpu_gnt, cpu_ack, vram_we_b, vram_oe_b, busy;
  logic [1:0] addr_sel;
`ifdef GFX_VBUS_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  always #5 clk = ~clk;

  gfx_vbus_arb #(
    .ACCESS_CYCLES (AC),
    .TURNAROUND    (TA)
  ) dut (
    .i_clk       (clk),
    .i_rst_b     (rst_b),
    .i_free_vbus (free),
    .i_dma_req   (dma_req),
    .o_dma_gnt   (dma_gnt),
    .o_dma_ack   (dma_ack),
    .i_cpu_req   (cpu_req),
    .i_cpu_we_b  (cpu_we_b),
    .o_cpu_gnt   (cpu_gnt),
    .o_cpu_ack   (cpu_ack),
    .o_addr_sel  (addr_sel),
    .o_vram_we_b (vram_we_b),
    .o_vram_oe_b (vram_oe_b),
    .o_busy      (busy)
`ifdef GFX_VBUS_ABORT_CNT_EN
    ,
    .o_abort_cnt (abort_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant is a sequence of m_turn idle cycles followed by AC access
  // cycles; m_pos counts cycles elapsed since the grant started (0 = none active).
  int m_own   = 0;  // 0 none, 1 DMA, 2 CPU
  int m_pos   = 0;
  int m_turn  = 0;
  int m_wr    = 0;
  int m_last  = 2;
  int m_abort = 0;

  function automatic int pick();
    if (dma_req && cpu_req) return (m_last == 1) ? 2 : 1;
    if (dma_req) return 1;
    if (cpu_req) return 2;
    return 0;
  endfunction

  task automatic start(input int p, input int t);
    m_own  = p;
    m_pos  = 0;
    m_turn = t;
    m_wr   = (p == 1) ? 1 : (cpu_we_b ? 0 : 1);
  endtask

  task automatic model_step();
    int p;
    logic rq;
    if (!rst_b) begin
      m_own = 0; m_last = 2; m_abort = 0;
      return;
    end
    p = pick();
    if (m_own == 0) begin
      if (free && p != 0) start(p, TA);
    end else if (m_pos - m_turn == AC - 1) begin
      if (free && p != 0) start(p, (p == m_own) ? 0 : TA);
      else m_own = 0;
    end else begin
      rq = (m_own == 1) ? dma_req : cpu_req;
      if (!free || !rq) begin
        if (!free && m_abort < 255) m_abort++;
        m_own = 0;
      end else begin
        m_pos++;
        if (m_pos - m_turn == AC - 1) m_last = m_own;
      end
    end
  endtask

  task automatic model_check();
    logic [1:0] sel;
    logic we, oe, dg, cg, da, ca, bz;
    int a;
    sel = 2'b00; we = 1'b1; oe = 1'b1; dg = 0; cg = 0; da = 0; ca = 0; bz = 0;
    if (m_own != 0) begin
      a   = m_pos - m_turn;
      sel = 2'(m_own);
      dg  = (m_own == 1);
      cg  = (m_own == 2);
      bz  = 1'b1;
      if (a >= 0) begin
        if (m_wr != 0) we = (a >= AC - 1);
        else oe = 1'b0;
        if (a == AC - 1) begin
          da = (m_own == 1);
          ca = (m_own == 2);
        end
      end
    end
    chk("m_addr_sel", addr_sel, sel);
    chk("m_we_b", vram_we_b, we);
    chk("m_oe_b", vram_oe_b, oe);
    chk("m_dma_gnt", dma_gnt, dg);
    chk("m_cpu_gnt", cpu_gnt, cg);
    chk("m_dma_ack", dma_ack, da);
    chk("m_cpu_ack", cpu_ack, ca);
    chk("m_busy", busy, bz);
`ifdef GFX_VBUS_ABORT_CNT_EN
    chk("m_abort_cnt", abort_cnt, m_abort);
`endif
  endtask

  // One clock: model advances on the same inputs the DUT samples; compare mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input logic r, input logic f, input logic d, input logic c,
                       input logic w);
    rst_b = r; free = f; dma_req = d; cpu_req = c; cpu_we_b = w;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    cyc();
  endtask

  typedef struct {
    logic       rst_b, free, dma, cpu, we_b;
    logic [1:0] sel;
    logic       we, oe, dack, cack, busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int  ack_at[$];
    bit  found;
    logic we_seen[7];

    // Single DMA write, then reset and a DMA/CPU tie resolved DMA-first.
    tbl[0]  = '{1, 1, 1, 0, 1, 2'd1, 1, 1, 0, 0, 1};
    tbl[1]  = '{1, 1, 1, 0, 1, 2'd1, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 1, 0, 1, 2'd1, 1, 1, 1, 0, 1};
    tbl[3]  = '{1, 1, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 1, 2'd1, 1, 1, 0, 0, 1};
    tbl[6]  = '{1, 1, 1, 1, 1, 2'd1, 0, 1, 0, 0, 1};
    tbl[7]  = '{1, 1, 1, 1, 1, 2'd1, 1, 1, 1, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 1, 2'd2, 1, 1, 0, 0, 1};
    tbl[9]  = '{1, 1, 0, 1, 1, 2'd2, 1, 0, 0, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 1, 2'd2, 1, 0, 0, 1, 1};
    tbl[11] = '{1, 1, 0, 0, 1, 2'd0, 1, 1, 0, 0, 0};

    @(negedge clk);
    do_reset();
    chk("reset_sel", addr_sel, 2'b00);
    chk("reset_we_oe", {vram_we_b, vram_oe_b}, 2'b11);
    chk("reset_gnt_ack_busy", {dma_gnt, cpu_gnt, dma_ack, cpu_ack, busy}, 5'b0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst_b, tbl[i].free, tbl[i].dma, tbl[i].cpu, tbl[i].we_b);
      cyc();
      chk($sformatf("vec%0d_sel", i), addr_sel, tbl[i].sel);
      chk($sformatf("vec%0d_we_b", i), vram_we_b, tbl[i].we);
      chk($sformatf("vec%0d_oe_b", i), vram_oe_b, tbl[i].oe);
      chk($sformatf("vec%0d_acks", i), {dma_ack, cpu_ack}, {tbl[i].dack, tbl[i].cack});
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
    end

    // VGA reclaims the bus in the first access cycle, then the DMA is retried.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    cyc();
    chk("abort_pre_we_b", vram_we_b, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("abort_sel", addr_sel, 2'b00);
    chk("abort_we_b", vram_we_b, 1'b1);
    chk("abort_no_ack_gnt", {dma_ack, dma_gnt}, 2'b00);
    cyc();
    chk("abort_idle_hold", addr_sel, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      cyc();
      if (dma_ack) found = 1;
    end
    chk("abort_retry_ack", found, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();

    // DMA holds req over three accesses: back-to-back, no turnaround between them.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cyc();
      we_seen[k] = vram_we_b;
      if (dma_ack) ack_at.push_back(k);
    end
    chk("b2b_ack_count", ack_at.size(), 3);
    if (ack_at.size() == 3) begin
      chk("b2b_ack0", ack_at[0], 2);
      chk("b2b_gap1", ack_at[1] - ack_at[0], 2);
      chk("b2b_gap2", ack_at[2] - ack_at[1], 2);
    end
    chk("b2b_no_turn", {we_seen[3], we_seen[5]}, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("b2b_release", addr_sel, 2'b00);

    // Reset during a CPU write access.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("rst_mid_turn_sel", addr_sel, 2'b10);
    cyc();
    chk("rst_mid_we_b", vram_we_b, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("rst_mid_sel", addr_sel, 2'b00);
    chk("rst_mid_strobes", {vram_we_b, vram_oe_b}, 2'b11);
    chk("rst_mid_outs", {cpu_gnt, cpu_ack, busy}, 3'b000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();

`ifdef GFX_VBUS_ABORT_CNT_EN
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc();
    end
    chk("abort_cnt_sat", abort_cnt, 8'hff);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("abort_cnt_clr", abort_cnt, 8'h00);
`endif

    // Randomized traffic; requesters hold req until ack, with occasional early drops.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      free = ($urandom_range(0, 99) < 85);
      rst_b = ($urandom_range(0, 499) != 0);
      if (dma_req) begin
        if (dma_ack) dma_req = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 49) == 0) dma_req = 1'b0;
      end else begin
        dma_req = ($urandom_range(0, 2) == 0);
      end
      if (cpu_req) begin
        if (cpu_ack) begin
          cpu_req  = 1'($urandom_range(0, 1));
          cpu_we_b = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 49) == 0) begin
          cpu_req = 1'b0;
        end
      end else begin
        cpu_req  = ($urandom_range(0, 2) == 0);
        cpu_we_b = 1'($urandom_range(0, 1));
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
